// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and defaults for the accumulator CPU.
//   opcode_e      : 3-bit instruction opcode carried in the top of each word.
//   fetch_state_e : state of the instruction fetch FSM.
//   ADDR_W_DEF / DATA_W_DEF : default address and instruction widths.
package cpu_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    HLT     = 3'd0,
    LDA     = 3'd1,
    ADD     = 3'd2,
    SUB     = 3'd3,
    AND_OP  = 3'd4,
    ACC_MEM = 3'd5,
    STO     = 3'd6,
    JMP     = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// pc_reg: program counter register with load / increment / skip logic.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   update_en     : PC may change this cycle (fetch FSM not waiting on memory)
//   halt          : freezes the PC
//   pc_load       : load pc from load_val (wins over pc_en)
//   pc_en         : advance pc by 1, or by 2 when skip is set
//   skip          : qualifies pc_en only
//   load_val      : jump target (the IR operand field)
//   pc            : current program counter
module pc_reg #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              update_en,
  input  logic              halt,
  input  logic              pc_load,
  input  logic              pc_en,
  input  logic              skip,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_value_reg;
  logic [ADDR_W-1:0] pc_value_next;

  always_comb begin
    pc_value_next = pc_value_reg;
    if (update_en && !halt) begin
      if (pc_load) begin
        pc_value_next = load_val;
      end else if (pc_en) begin
        // Wraps naturally modulo 2^ADDR_W.
        pc_value_next = pc_value_reg + ADDR_W'(1) + ADDR_W'(skip);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_value_reg <= '0;
    end else begin
      pc_value_reg <= pc_value_next;
    end
  end

  assign pc = pc_value_reg;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit. Owns the PC and the instruction
// register; reads one word from instruction memory per fetch_start over a
// variable-latency req/ack handshake, with a timeout that sets a sticky error.
// Ports:
//   clk, rst                     : clock, asynchronous active-low reset
//   fetch_start                  : start a fetch at the current pc
//   pc_en, skip, pc_load, halt   : PC control (see pc_reg)
//   imem_req/imem_addr           : memory read request and address (held until ack)
//   imem_rdata/imem_ack          : memory read data and completion
//   opcode, operand              : fields of the instruction register
//   ir_valid                     : IR holds a completed fetch
//   pc                           : program counter
//   busy                         : fetch in flight
//   fetch_err                    : sticky timeout flag, cleared only by reset
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic              pc_en,
  input  logic              skip,
  input  logic              pc_load,
  input  logic              halt,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic [2:0]        opcode,
  output logic [ADDR_W-1:0] operand,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_e      state_reg, state_next;
  logic              req_reg, req_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] ir_reg, ir_next;
  logic              ir_valid_reg, ir_valid_next;
  logic              err_reg, err_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  always_comb begin
    state_next    = state_reg;
    req_next      = req_reg;
    addr_next     = addr_reg;
    ir_next       = ir_reg;
    ir_valid_next = ir_valid_reg;
    err_next      = err_reg;
    cnt_next      = cnt_reg;
    case (state_reg)
      IDLE, VALID: begin
        // The fetch captures the pc before any same-cycle PC update lands.
        if (fetch_start && !halt && !err_reg) begin
          state_next    = REQ;
          addr_next     = pc;
          req_next      = 1'b1;
          ir_valid_next = 1'b0;
          cnt_next      = '0;
        end
      end
      REQ: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (imem_ack) begin
          ir_next       = imem_rdata;
          ir_valid_next = 1'b1;
          req_next      = 1'b0;
          state_next    = VALID;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          req_next   = 1'b0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      req_reg      <= 1'b0;
      addr_reg     <= '0;
      ir_reg       <= '0;
      ir_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      req_reg      <= req_next;
      addr_reg     <= addr_next;
      ir_reg       <= ir_next;
      ir_valid_reg <= ir_valid_next;
      err_reg      <= err_next;
      cnt_reg      <= cnt_next;
    end
  end

  pc_reg #(
    .ADDR_W(ADDR_W)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .update_en(state_reg != REQ),
    .halt     (halt),
    .pc_load  (pc_load),
    .pc_en    (pc_en),
    .skip     (skip),
    .load_val (operand),
    .pc       (pc)
  );

  assign imem_req  = req_reg;
  assign imem_addr = addr_reg;
  assign opcode    = ir_reg[DATA_W-1:ADDR_W];
  assign operand   = ir_reg[ADDR_W-1:0];
  assign ir_valid  = ir_valid_reg;
  assign busy      = (state_reg == REQ);
  assign fetch_err = err_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: table-driven vectors, hand-written multi-cycle
// sequences (delayed ack, timeout, reset mid-fetch) and a randomized run
// checked against a behavioural model of the fetch unit.
module tb_instr_fetch;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_start = 1'b0;
  logic          pc_en = 1'b0;
  logic          skip = 1'b0;
  logic          pc_load = 1'b0;
  logic          halt = 1'b0;
  logic          imem_ack = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [2:0]    opcode;
  logic [AW-1:0] operand;
  logic          ir_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          fetch_err;

  int n_total = 0;
  int n_bad = 0;

  instr_fetch #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .fetch_start(fetch_start),
    .pc_en      (pc_en),
    .skip       (skip),
    .pc_load    (pc_load),
    .halt       (halt),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .opcode     (opcode),
    .operand    (operand),
    .ir_valid   (ir_valid),
    .pc         (pc),
    .busy       (busy),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, exp finish before 2ms");
    $fatal(1, "watchdog");
  end

  // {pc, req, addr, ir_valid, busy, opcode, operand, fetch_err}
  logic [21:0] got;
  assign got = {pc, imem_req, imem_addr, ir_valid, busy, opcode, operand, fetch_err};

  function automatic logic [21:0] pack_exp(int p, bit req, int a, bit v, int opc, int opr, bit err);
    return {5'(p), req, 5'(a), v, req, 3'(opc), 5'(opr), err};
  endfunction

  task automatic check(input string name, input logic [21:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got pc=%0d req=%0b addr=%0d valid=%0b busy=%0b op=%0d opr=%0d err=%0b | exp pc=%0d req=%0b addr=%0d valid=%0b busy=%0b op=%0d opr=%0d err=%0b",
               name, got[21:17], got[16], got[15:11], got[10], got[9], got[8:6], got[5:1], got[0],
               exp[21:17], exp[16], exp[15:11], exp[10], exp[9], exp[8:6], exp[5:1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit fs, input bit pe, input bit sk, input bit pl, input bit h,
                        input bit ack, input logic [7:0] rd);
    fetch_start = fs;
    pc_en       = pe;
    skip        = sk;
    pc_load     = pl;
    halt        = h;
    imem_ack    = ack;
    imem_rdata  = rd;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 8'h00);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    check("reset_state", pack_exp(0, 0, 0, 0, 0, 0, 0));
  endtask

  typedef struct {
    bit          fs, pe, sk, pl, h, ack;
    logic [7:0]  rdata;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(bit fs, bit pe, bit sk, bit pl, bit h, bit ack, logic [7:0] rd,
                              logic [21:0] exp);
    vec_t v;
    v.fs = fs; v.pe = pe; v.sk = sk; v.pl = pl; v.h = h; v.ack = ack;
    v.rdata = rd;
    v.exp = exp;
    return v;
  endfunction

  // Behavioural model for the randomized run.
  logic [7:0] mem[32];
  int         m_pc, m_addr, m_wait;
  bit         m_busy, m_valid, m_err;
  logic [7:0] m_ir;

  task automatic model_reset();
    m_pc = 0; m_addr = 0; m_wait = 0;
    m_busy = 0; m_valid = 0; m_err = 0;
    m_ir = 8'h00;
  endtask

  task automatic model_step(input bit fs, input bit pe, input bit sk, input bit pl, input bit h,
                            input bit ack, input logic [7:0] rd);
    int new_pc;
    if (m_busy) begin
      if (ack) begin
        m_ir = rd;
        m_valid = 1;
        m_busy = 0;
        $display("fetch addr=%0d word=%h waited=%0d", m_addr, rd, m_wait);
      end else if (m_wait == TO - 1) begin
        m_err = 1;
        m_busy = 0;
        $display("fetch addr=%0d timed out", m_addr);
      end else begin
        m_wait++;
      end
    end else begin
      new_pc = m_pc;
      if (!h) begin
        if (pl) new_pc = int'(m_ir[4:0]);
        else if (pe) new_pc = (m_pc + 1 + int'(sk)) % 32;
      end
      if (fs && !h && !m_err) begin
        m_busy = 1;
        m_addr = m_pc;
        m_valid = 0;
        m_wait = 0;
      end
      m_pc = new_pc;
    end
  endtask

  initial begin
    // fs pe sk pl h ack rdata | pc req addr valid opc opr err
    vecs[0]  = mk(1,0,0,0,0,0,8'h00, pack_exp(0, 1,0,0,0,0,0));
    vecs[1]  = mk(0,0,0,0,0,1,8'hE5, pack_exp(0, 0,0,1,7,5,0));
    vecs[2]  = mk(0,0,0,1,0,0,8'h00, pack_exp(5, 0,0,1,7,5,0));
    vecs[3]  = mk(1,0,0,0,0,0,8'h00, pack_exp(5, 1,5,0,7,5,0));
    vecs[4]  = mk(0,0,0,0,0,1,8'h1F, pack_exp(5, 0,5,1,0,31,0));
    vecs[5]  = mk(0,0,0,1,0,0,8'h00, pack_exp(31,0,5,1,0,31,0));
    vecs[6]  = mk(0,1,0,0,0,0,8'h00, pack_exp(0, 0,5,1,0,31,0));
    vecs[7]  = mk(1,0,0,0,0,0,8'h00, pack_exp(0, 1,0,0,0,31,0));
    vecs[8]  = mk(0,0,0,0,0,1,8'h1E, pack_exp(0, 0,0,1,0,30,0));
    vecs[9]  = mk(0,0,0,1,0,0,8'h00, pack_exp(30,0,0,1,0,30,0));
    vecs[10] = mk(0,1,1,0,0,0,8'h00, pack_exp(0, 0,0,1,0,30,0));
    vecs[11] = mk(1,0,0,0,0,0,8'h00, pack_exp(0, 1,0,0,0,30,0));
    vecs[12] = mk(0,0,0,0,0,1,8'hA9, pack_exp(0, 0,0,1,5,9,0));
    vecs[13] = mk(0,1,0,1,0,0,8'h00, pack_exp(9, 0,0,1,5,9,0));
    vecs[14] = mk(1,1,0,0,1,0,8'h00, pack_exp(9, 0,0,1,5,9,0));
    vecs[15] = mk(0,0,0,1,1,0,8'h00, pack_exp(9, 0,0,1,5,9,0));
    vecs[16] = mk(0,0,1,0,0,0,8'h00, pack_exp(9, 0,0,1,5,9,0));
    vecs[17] = mk(0,0,0,0,0,1,8'hFF, pack_exp(9, 0,0,1,5,9,0));
    vecs[18] = mk(1,1,0,0,0,0,8'h00, pack_exp(10,1,9,0,5,9,0));
    vecs[19] = mk(0,1,0,0,1,0,8'h00, pack_exp(10,1,9,0,5,9,0));
    vecs[20] = mk(0,0,0,0,1,1,8'hC3, pack_exp(10,0,9,1,6,3,0));

    // Table-driven vectors.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      set_in(vecs[i].fs, vecs[i].pe, vecs[i].sk, vecs[i].pl, vecs[i].h, vecs[i].ack, vecs[i].rdata);
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp);
      $display("vec %0d: pc=%0d req=%0b addr=%0d valid=%0b op=%0d opr=%0d",
               i, pc, imem_req, imem_addr, ir_valid, opcode, operand);
    end
    set_in(0, 0, 0, 0, 0, 0, 8'h00);

    // Ack delayed by 5 cycles; pc_en during REQ must be ignored.
    do_reset();
    set_in(0, 1, 0, 0, 0, 0, 8'h00); tick();
    tick();
    check("pc_inc", pack_exp(2, 0, 0, 0, 0, 0, 0));
    set_in(1, 0, 0, 0, 0, 0, 8'h00); tick();
    check("delay_req", pack_exp(2, 1, 2, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      set_in(0, (i == 2), 0, 0, 0, 0, 8'h00);
      tick();
      check($sformatf("delay_wait%0d", i), pack_exp(2, 1, 2, 0, 0, 0, 0));
    end
    set_in(0, 0, 0, 0, 0, 1, 8'h6A); tick();
    check("delay_ack", pack_exp(2, 0, 2, 1, 3, 10, 0));
    $display("delayed ack: word=6a op=%0d opr=%0d", opcode, operand);

    // Timeout: req high for exactly TO cycles, then sticky error.
    set_in(1, 0, 0, 0, 0, 0, 8'h00); tick();
    check("to_req", pack_exp(2, 1, 2, 0, 3, 10, 0));
    set_in(0, 0, 0, 0, 0, 0, 8'h00);
    for (int k = 1; k < TO; k++) begin
      tick();
      check($sformatf("to_wait%0d", k), pack_exp(2, 1, 2, 0, 3, 10, 0));
    end
    tick();
    check("to_err", pack_exp(2, 0, 2, 0, 3, 10, 1));
    set_in(1, 0, 0, 0, 0, 0, 8'h00); tick();
    check("to_ignore_start", pack_exp(2, 0, 2, 0, 3, 10, 1));
    $display("timeout: err=%0b req=%0b", fetch_err, imem_req);

    // Reset asserted 2 cycles into REQ.
    do_reset();
    set_in(0, 1, 0, 0, 0, 0, 8'h00); tick();
    set_in(1, 0, 0, 0, 0, 0, 8'h00); tick();
    check("rst_req", pack_exp(1, 1, 1, 0, 0, 0, 0));
    set_in(0, 0, 0, 0, 0, 0, 8'h00);
    tick(); tick();
    #2;
    rst_n = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 8'hE5;
    #1;
    check("rst_async", pack_exp(0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    imem_ack = 1'b0;
    tick();
    check("rst_idle", pack_exp(0, 0, 0, 0, 0, 0, 0));
    set_in(1, 0, 0, 0, 0, 0, 8'h00); tick();
    check("rst_refetch", pack_exp(0, 1, 0, 0, 0, 0, 0));
    $display("reset mid-fetch: req=%0b pc=%0d", imem_req, pc);

    // Randomized run against the behavioural model.
    for (int a = 0; a < 32; a++) mem[a] = 8'($urandom);
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
        bit fs, pe, sk, pl, h, ack;
        logic [7:0] rd;
        fs  = ($urandom_range(0, 3) == 0);
        pe  = ($urandom_range(0, 3) == 0);
        sk  = $urandom_range(0, 1) == 1;
        pl  = ($urandom_range(0, 7) == 0);
        h   = ($urandom_range(0, 7) == 0);
        ack = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        rd  = m_busy ? mem[m_addr] : 8'($urandom);
        set_in(fs, pe, sk, pl, h, ack, rd);
        model_step(fs, pe, sk, pl, h, ack, rd);
        tick();
        check($sformatf("rand_s%0d_c%0d", seg, cyc),
              pack_exp(m_pc, m_busy, m_addr, m_valid, int'(m_ir[7:5]), int'(m_ir[4:0]), m_err));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the accumulator CPU. It owns the program counter and the instruction register. On request from the control FSM it reads one instruction word from instruction memory over a variable-latency req/ack handshake. It splits the word into `opcode` (which feeds the controller) and `operand` (the address field).

## Interface
Parameters:
- `ADDR_W`, default 5: PC and operand width.
- `DATA_W`, default 8: instruction width, laid out as {opcode[2:0], operand[ADDR_W-1:0]}. DATA_W must equal 3+ADDR_W.
- `TIMEOUT`, default 16: maximum number of cycles to wait for `imem_ack`. Must be ≥2.

Ports:
- `clk`  in  1  rising-edge clock; one clock; reset is asynchronous and active-low.
- `rst`  in  1  asynchronous, active-low reset.
- `fetch_start`  in  1  single-cycle request from the controller's fetch state.
- `pc_en`  in  1  advance the PC.
- `skip`  in  1  qualifies `pc_en`: advance by 2 instead of 1.
- `pc_load`  in  1  load the PC from `operand`.
- `halt`  in  1  freezes fetch starts and PC updates.
- `imem_req`  out  1  memory read request.
- `imem_addr`  out  ADDR_W  read address.
- `imem_rdata`  in  DATA_W  read data; valid when `imem_ack`=1.
- `imem_ack`  in  1  read completion.
- `opcode`  out  3  `ir[DATA_W-1:ADDR_W]`.
- `operand`  out  ADDR_W  `ir[ADDR_W-1:0]`.
- `ir_valid`  out  1  the IR holds a completed fetch.
- `pc`  out  ADDR_W  current program counter.
- `busy`  out  1  a fetch is in flight.
- `fetch_err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, REQ, VALID. Reset places the FSM in IDLE.
- Reset values: `pc`=0, `ir`=0, `imem_req`=0, `imem_addr`=0, `ir_valid`=0, `busy`=0, `fetch_err`=0, timeout counter=0.
- IDLE or VALID, with `fetch_start`=1, `halt`=0 and `fetch_err`=0:
  - Next state is REQ.
  - `imem_addr` <= `pc`, `imem_req` <= 1, `ir_valid` <= 0, counter <= 0.
- REQ:
  - `imem_req` and `imem_addr` are held stable until the ack.
  - On `imem_ack`=1: `ir` <= `imem_rdata`, `ir_valid` <= 1, `imem_req` <= 0, next state is VALID.
  - Otherwise the counter increments. If no ack arrives by the cycle the counter equals TIMEOUT-1: `fetch_err` <= 1, `imem_req` <= 0, next state is IDLE, `ir` is unchanged, `ir_valid` stays 0.
  - `fetch_start`, `pc_en` and `pc_load` are ignored.
  - `halt` does not abort an in-flight fetch.
- PC update (IDLE and VALID only, and only while `halt`=0):
  - Priority is `pc_load` > `pc_en`.
  - `pc_load`: `pc` <= `operand`.
  - `pc_en`: `pc` <= `pc` + 1 + `skip`, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - `skip` without `pc_en` has no effect.
- A PC update and `fetch_start` in the same cycle: the fetch uses the old `pc`, and the PC update still takes effect.
- `fetch_err` is cleared only by reset. While it is set, `fetch_start` is ignored.
- `busy` = (state == REQ).

## Timing
- All outputs are registered except `opcode`, `operand` and `busy`, which are decoded directly from registers.
- Minimum latency: `fetch_start` in cycle 0 → `imem_req` high in cycle 1. An ack in cycle 1 → `ir_valid` and the new `opcode` appear in cycle 2.
- An ack N cycles after `imem_req` rises gives `ir_valid` N+1 cycles after `imem_req` rises.
- `imem_ack` is sampled only while in REQ. Acks arriving in IDLE or VALID are dropped.
- Asserting `rst` mid-fetch drops `imem_req` immediately (asynchronously) and applies all reset values.

## Structure
- Shared package `cpu_pkg` holds:
  - `opcode_e` (3-bit, with HLT=0, ACC_MEM=5, STO=6, JMP=7 and the remaining codes).
  - Default ADDR_W and DATA_W localparams.
  - `fetch_state_e` {IDLE, REQ, VALID}.
- One sub-module, `pc_reg`, contains the PC register plus the load/increment/skip/halt logic. Everything else stays in `instr_fetch`.

## Test plan
- Reset, then `fetch_start` with `pc`=0 and an ack 1 cycle after req carrying 8'hE5:
  - `ir_valid` rises 2 cycles after `fetch_start`.
  - `opcode`=7, `operand`=5, `imem_addr`=0.
- Ack delayed by 5 cycles:
  - `imem_req` and `imem_addr` stay stable throughout.
  - `pc_en` pulsed during REQ leaves `pc` unchanged.
  - `ir_valid` rises exactly 1 cycle after the ack.
- With `pc`=31 (ADDR_W=5):
  - `pc_en` → `pc`=0.
  - `pc_en`+`skip` from `pc`=30 → 0.
  - `pc_load` and `pc_en` together with `operand`=9 → `pc`=9.
- No ack with TIMEOUT=16:
  - `fetch_err` is set and `imem_req` drops 16 cycles after req rose.
  - A subsequent `fetch_start` is ignored.
- `halt`=1:
  - `fetch_start` and `pc_en` have no effect.
  - A fetch already in REQ still completes on ack.
- `rst` asserted 2 cycles into REQ: `imem_req`=0 immediately, `pc`=0, `ir_valid`=0, FSM in IDLE after release.
